data_memory_be: RTL and testbench
=================================

DATA_MEMORY_BE -- requirements
Module: data_memory_be

Interface
REQ-001: Parameter DATA_WIDTH, default 32, word width in bits; SHALL be a multiple of 8 (8..64).
REQ-002: Parameter ADDR_WIDTH, default 10, address width in bits.
REQ-003: Parameter DEPTH, default 1000, number of implemented words; SHALL satisfy 1 <= DEPTH <= 2^ADDR_WIDTH.
REQ-004: Parameter READ_LATENCY, default 1, read pipeline depth; legal values 1 or 2.
REQ-005: clk  input  1  single clock; all state updates on rising edge.
REQ-006: rst  input  1  reset, synchronous, active-high.
REQ-007: WriteEn  input  1  write request.
REQ-008: ReadEn  input  1  read request.
REQ-009: ByteEn  input  DATA_WIDTH/8  per-byte write mask; bit k gates WriteData[8k+7:8k].
REQ-010: Address  input  ADDR_WIDTH  word address for read and write.
REQ-011: WriteData  input  DATA_WIDTH  write data.
REQ-012: ReadData  output  DATA_WIDTH  registered read data.
REQ-013: ReadValid  output  1  one-cycle pulse marking ReadData valid.
REQ-014: Ready  output  1  high when the block accepts requests.
REQ-015: AddrErr  output  1  one-cycle pulse flagging an access with Address >= DEPTH.

Function
REQ-016: The block SHALL implement a two-state FSM: INIT and READY.
REQ-017: INIT: an internal counter SHALL sweep addresses 0..DEPTH-1, writing all-zero to one word per cycle; Ready SHALL be 0.
REQ-018: INIT -> READY on the edge that clears word DEPTH-1; Ready SHALL be 1 in the following cycle; sweep therefore takes exactly DEPTH cycles after rst deasserts.
REQ-019: READY SHALL persist until rst; no other transition exists.
REQ-020: WriteEn, ReadEn, ByteEn, Address, WriteData SHALL be ignored while Ready=0 (no write, no ReadValid, no AddrErr).
REQ-021: Write: when Ready=1, WriteEn=1, Address<DEPTH, bytes with ByteEn[k]=1 SHALL update at the sampling edge; bytes with ByteEn[k]=0 SHALL retain old value; ByteEn=0 SHALL leave the word unchanged.
REQ-022: Read: a ReadEn sampled at edge N with Address<DEPTH SHALL produce ReadData and ReadValid=1 after edge N+READ_LATENCY-1, for exactly one cycle per request.
REQ-023: Back-to-back reads (ReadEn high every cycle) SHALL be fully pipelined, one result per cycle, in request order.
REQ-024: ReadData SHALL hold its last value while ReadValid=0.
REQ-025: Simultaneous WriteEn and ReadEn to the same address SHALL return the pre-write data (read-first); the write SHALL still take effect.
REQ-026: A read issued the cycle after a write to the same address SHALL return the newly written data.
REQ-027: Address >= DEPTH: write SHALL be dropped; read SHALL return ReadData=0 with ReadValid=1 at normal latency; AddrErr SHALL pulse 1 cycle after the sampling edge.
REQ-028: AddrErr SHALL not assert for an out-of-range address when both WriteEn and ReadEn are 0.

Reset
REQ-029: rst=1 at an edge SHALL set Ready=0, ReadValid=0, AddrErr=0, ReadData=0, FSM=INIT, sweep counter=0.
REQ-030: rst SHALL flush in-flight reads; no ReadValid SHALL appear for requests sampled before or during rst.
REQ-031: rst asserted mid-INIT SHALL restart the sweep from address 0.
REQ-032: rst asserted in READY SHALL re-run the full clear; all words SHALL read 0 afterwards.

Verification
REQ-033: Pulse rst 1 cycle, count cycles -> Ready rises exactly DEPTH (1000) cycles after rst deasserts; reads of addresses 0, 500, 999 return 0x00000000.
REQ-034: Write 0xDEADBEEF ByteEn=4'b1111 to addr 5, then write 0x11223344 ByteEn=4'b0101 to addr 5, read addr 5 -> ReadData=0xDE22BE44, ReadValid one pulse at latency 1 (repeat with READ_LATENCY=2 -> one cycle later).
REQ-035: Addr 7 holds 0x0000AAAA; same cycle WriteEn+ReadEn to addr 7 with 0x5555BBBB ByteEn=4'b1111 -> ReadData=0x0000AAAA; next-cycle read -> 0x5555BBBB.
REQ-036: Write addr i data i for i=1..50, then ReadEn high 50 consecutive cycles addr 1..50 -> 50 consecutive ReadValid pulses, ReadData=1..50 in order.
REQ-037: Write to addr 1000 and read addr 1023 -> AddrErr pulses each time; read returns 0; word 999 unchanged.
REQ-038: Issue read of addr 5, assert rst the next cycle; also assert rst at sweep address 300 -> no ReadValid for the flushed read; Ready rises 1000 cycles after the last rst deassertion; addr 5 reads 0.

Source files
------------

// File: rtl/data_memory_be.sv
// Byte-enable data memory with a self-clearing INIT sweep after reset.
// Reads are pipelined, read-first, and have a latency of 1 or 2 cycles.
module data_memory_be #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int DEPTH        = 1000,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    WriteEn,
    input  logic                    ReadEn,
    input  logic [DATA_WIDTH/8-1:0] ByteEn,
    input  logic [ADDR_WIDTH-1:0]   Address,
    input  logic [DATA_WIDTH-1:0]   WriteData,
    output logic [DATA_WIDTH-1:0]   ReadData,
    output logic                    ReadValid,
    output logic                    Ready,
    output logic                    AddrErr
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    localparam logic [0:0] S_INIT  = 1'b0;
    localparam logic [0:0] S_READY = 1'b1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_v1;
    logic [DATA_WIDTH-1:0] r_d1;
    logic                  r_err;

    logic                  w_ready;
    logic                  w_in_range;
    logic [IW-1:0]         w_idx;
    logic [IW-1:0]         w_sweep_idx;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_sweep;
    logic                  w_err;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_ready     = (r_state == S_READY);
    assign w_in_range  = (Address <= LAST);
    assign w_idx       = Address[IW-1:0];
    assign w_sweep_idx = r_cnt[IW-1:0];
    assign w_wr        = w_ready & WriteEn & w_in_range & ~rst;
    assign w_rd        = w_ready & ReadEn & ~rst;
    assign w_sweep     = ~w_ready & ~rst;
    assign w_err       = w_ready & (WriteEn | ReadEn) & ~w_in_range & ~rst;
    assign w_rdata     = w_in_range ? r_mem[w_idx] : '0;

    // The sweep counter parks on the last word once READY is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
        end else if (r_state == S_INIT) begin
            if (r_cnt == LAST) begin
                r_state <= S_READY;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_sweep) begin
            r_mem[w_sweep_idx] <= '0;
        end else if (w_wr) begin
            for (int k = 0; k < NB; k++) begin
                if (ByteEn[k]) begin
                    r_mem[w_idx][8*k +: 8] <= WriteData[8*k +: 8];
                end
            end
        end
    end

    // Read-first: the array is sampled before this edge's write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1  <= 1'b0;
            r_d1  <= '0;
            r_err <= 1'b0;
        end else begin
            r_v1  <= w_rd;
            r_err <= w_err;
            if (w_rd) begin
                r_d1 <= w_rdata;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  r_v2;
            logic [DATA_WIDTH-1:0] r_d2;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v2 <= 1'b0;
                    r_d2 <= '0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_d2 <= r_d1;
                    end
                end
            end

            assign ReadValid = r_v2;
            assign ReadData  = r_d2;
        end else begin : g_lat1
            assign ReadValid = r_v1;
            assign ReadData  = r_d1;
        end
    endgenerate

    assign Ready   = w_ready;
    assign AddrErr = r_err;

endmodule

// File: tb/tb_data_memory_be.sv
// Directed bench for data_memory_be: one latency-1 and one latency-2 instance
// driven by the same stimulus, checked against hand-computed values.
module tb_data_memory_be;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic        re;
    logic [3:0]  be;
    logic [9:0]  addr;
    logic [31:0] wdata;

    logic [31:0] rd1, rd2;
    logic        rv1, rv2, rdy1, rdy2, ae1, ae2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_memory_be #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(1000), .READ_LATENCY(1)
    ) u1 (
        .clk(clk), .rst(rst), .WriteEn(we), .ReadEn(re), .ByteEn(be),
        .Address(addr), .WriteData(wdata), .ReadData(rd1),
        .ReadValid(rv1), .Ready(rdy1), .AddrErr(ae1)
    );

    data_memory_be #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(1000), .READ_LATENCY(2)
    ) u2 (
        .clk(clk), .rst(rst), .WriteEn(we), .ReadEn(re), .ByteEn(be),
        .Address(addr), .WriteData(wdata), .ReadData(rd2),
        .ReadValid(rv2), .Ready(rdy2), .AddrErr(ae2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        we = 1'b0; re = 1'b0; be = 4'h0; addr = '0; wdata = '0;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d,
                      input logic [3:0] m);
        we = 1'b1; re = 1'b0; addr = a; wdata = d; be = m;
        tick();
        idle();
    endtask

    task automatic rd_check(input string tag, input logic [9:0] a,
                            input logic [31:0] exp);
        we = 1'b0; re = 1'b1; addr = a;
        tick();
        idle();
        check({tag, "_v1"}, rv1, 1);
        check({tag, "_d1"}, rd1, exp);
        check({tag, "_v2early"}, rv2, 0);
        tick();
        check({tag, "_v1off"}, rv1, 0);
        check({tag, "_d1hold"}, rd1, exp);
        check({tag, "_v2"}, rv2, 1);
        check({tag, "_d2"}, rd2, exp);
        tick();
        check({tag, "_v2off"}, rv2, 0);
    endtask

    task automatic wait_ready(input string tag);
        int cnt;
        logic seen;
        cnt  = 0;
        seen = 1'b0;
        while (!rdy1 && cnt < 2000) begin
            idle();
            if (cnt == 500) begin
                we = 1'b1; re = 1'b1; addr = 10'd3;
                wdata = 32'hFFFF_FFFF; be = 4'hF;
            end else if (cnt == 501) begin
                we = 1'b1; re = 1'b1; addr = 10'd1023; be = 4'hF;
            end
            tick();
            cnt++;
            seen = seen | rv1 | rv2 | ae1 | ae2;
        end
        idle();
        check({tag, "_cycles"}, cnt, 1000);
        check({tag, "_rdy2"}, rdy2, 1);
        check({tag, "_quiet"}, seen, 0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        check("rst_ready", rdy1, 0);
        check("rst_valid", rv1, 0);
        check("rst_err", ae1, 0);
        check("rst_data", rd1, 0);
        check("rst_data2", rd2, 0);
        rst = 1'b0;
        wait_ready("init");

        rd_check("clr0", 10'd0, 32'h0);
        rd_check("clr500", 10'd500, 32'h0);
        rd_check("clr999", 10'd999, 32'h0);
        rd_check("init_wr_ignored", 10'd3, 32'h0);

        wr(10'd5, 32'hDEAD_BEEF, 4'b1111);
        wr(10'd5, 32'h1122_3344, 4'b0101);
        rd_check("be_merge", 10'd5, 32'hDE22_BE44);
        wr(10'd5, 32'h0000_0000, 4'b0000);
        rd_check("be_none", 10'd5, 32'hDE22_BE44);

        wr(10'd7, 32'h0000_AAAA, 4'b1111);
        we = 1'b1; re = 1'b1; addr = 10'd7;
        wdata = 32'h5555_BBBB; be = 4'hF;
        tick();
        idle();
        check("rdfirst_v", rv1, 1);
        check("rdfirst_d", rd1, 32'h0000_AAAA);
        re = 1'b1; addr = 10'd7;
        tick();
        idle();
        check("rdafter_v", rv1, 1);
        check("rdafter_d", rd1, 32'h5555_BBBB);
        check("rdfirst_d2", rd2, 32'h0000_AAAA);
        tick();
        tick();

        for (int i = 1; i <= 50; i++) wr(10'(i), 32'(i), 4'hF);
        for (int i = 1; i <= 50; i++) begin
            re = 1'b1; addr = 10'(i);
            tick();
            check("burst_v1", rv1, 1);
            check("burst_d1", rd1, 32'(i));
            if (i >= 2) begin
                check("burst_v2", rv2, 1);
                check("burst_d2", rd2, 32'(i - 1));
            end
        end
        idle();
        tick();
        check("burst_end_v1", rv1, 0);
        check("burst_end_v2", rv2, 1);
        check("burst_end_d2", rd2, 32'd50);
        tick();

        wr(10'd1000, 32'hFFFF_FFFF, 4'hF);
        check("oor_wr_err", ae1, 1);
        check("oor_wr_valid", rv1, 0);
        tick();
        check("oor_wr_errpulse", ae1, 0);
        re = 1'b1; addr = 10'd1023;
        tick();
        idle();
        check("oor_rd_err", ae1, 1);
        check("oor_rd_err2", ae2, 1);
        check("oor_rd_v", rv1, 1);
        check("oor_rd_d", rd1, 0);
        tick();
        check("oor_rd_errpulse", ae1, 0);
        check("oor_rd_d2", rd2, 0);
        addr = 10'd1023;
        tick();
        check("oor_noen_err", ae1, 0);
        idle();
        rd_check("oor_keep999", 10'd999, 32'h0);

        re = 1'b1; addr = 10'd5;
        tick();
        rst = 1'b1;
        tick();
        check("flush_v1", rv1, 0);
        check("flush_v2", rv2, 0);
        check("flush_d1", rd1, 0);
        check("flush_d2", rd2, 0);
        check("flush_rdy", rdy1, 0);
        rst = 1'b0;
        idle();
        tick();
        check("flush_v2_late", rv2, 0);
        for (int i = 1; i < 300; i++) tick();
        check("mid_init_rdy", rdy1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_ready("reinit");
        rd_check("reclr5", 10'd5, 32'h0);
        rd_check("reclr7", 10'd7, 32'h0);
        rd_check("reclr50", 10'd50, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
